// File: rtl/ball_flipper_collision.sv
// Ball/flipper collision detector: counts overlapping pixels per frame and
// issues one bounce pulse per contact, followed by a per-frame cooldown.
module ball_flipper_collision #(
  parameter int MIN_OVERLAP     = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int MAX_SPEED_X     = 300,
  parameter int MIN_BOUNCE_Y    = 100
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        pause,
  input  logic        draw_ball,
  input  logic        draw_flipper,
  input  logic [31:0] flipperSpeedX,
  input  logic [31:0] ballSpeedX,
  input  logic [31:0] ballSpeedY,
  output logic        hit,
  output logic [31:0] newSpeedX,
  output logic [31:0] newSpeedY,
  output logic [15:0] hitCount
);

  typedef enum logic {ARMED, COOLDOWN} state_t;

  localparam logic [15:0]        MIN_OV  = 16'(MIN_OVERLAP);
  localparam logic [15:0]        CD_INIT = 16'(COOLDOWN_FRAMES);
  localparam logic signed [32:0] MAX_X   = 33'(MAX_SPEED_X);
  localparam logic [31:0]        MIN_Y   = 32'(MIN_BOUNCE_Y);

  state_t      state_q;
  logic [15:0] ovl_cnt_q;
  logic [15:0] cd_cnt_q;
  logic        hit_q;
  logic [31:0] spd_x_q;
  logic [31:0] spd_y_q;
  logic [15:0] hit_cnt_q;

  logic               ovl;
  logic signed [32:0] sx_wide;
  logic [31:0]        sx_d;
  logic [31:0]        ay;
  logic [31:0]        sy_d;

  assign ovl = draw_ball & draw_flipper & ~pause;

  // 33-bit sum so the clamp sees the true value even on 32-bit overflow
  always_comb begin
    sx_wide = $signed({ballSpeedX[31], ballSpeedX})
            + $signed({{2{flipperSpeedX[31]}}, flipperSpeedX[31:1]});
    sx_d = sx_wide[31:0];
    if (sx_wide > MAX_X) begin
      sx_d = MAX_X[31:0];
    end else if (sx_wide < -MAX_X) begin
      sx_d = 32'(-MAX_X);
    end
  end

  always_comb begin
    ay = ballSpeedY;
    if (ballSpeedY == 32'h8000_0000) begin
      ay = 32'h7FFF_FFFF;
    end else if (ballSpeedY[31]) begin
      ay = 32'd0 - ballSpeedY;
    end
    if (ay < MIN_Y) begin
      ay = MIN_Y;
    end
    sy_d = 32'd0 - ay;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ARMED;
      ovl_cnt_q <= '0;
      cd_cnt_q  <= '0;
      hit_q     <= 1'b0;
      spd_x_q   <= '0;
      spd_y_q   <= '0;
      hit_cnt_q <= '0;
    end else begin
      hit_q <= 1'b0;
      if (startOfFrame) begin
        ovl_cnt_q <= {15'd0, ovl};
      end else if (ovl && ovl_cnt_q != 16'hFFFF) begin
        ovl_cnt_q <= ovl_cnt_q + 16'd1;
      end
      if (startOfFrame && !pause) begin
        unique case (state_q)
          ARMED: begin
            if (ovl_cnt_q >= MIN_OV) begin
              hit_q    <= 1'b1;
              spd_x_q  <= sx_d;
              spd_y_q  <= sy_d;
              state_q  <= COOLDOWN;
              cd_cnt_q <= CD_INIT;
              if (hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
              end
            end
          end
          COOLDOWN: begin
            if (cd_cnt_q <= 16'd1) begin
              cd_cnt_q <= '0;
              state_q  <= ARMED;
            end else begin
              cd_cnt_q <= cd_cnt_q - 16'd1;
            end
          end
          default: state_q <= ARMED;
        endcase
      end
    end
  end

  assign hit       = hit_q;
  assign newSpeedX = spd_x_q;
  assign newSpeedY = spd_y_q;
  assign hitCount  = hit_cnt_q;

endmodule
